// File: rtl/uart_rx_mv_if.sv
// uart_rx_mv_if: word handshake and status bundle between the UART receiver
// (master) and its consumer, the packet parser (slave).
interface uart_rx_mv_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_busy;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;

    modport master (
        output rx_data, rx_valid, rx_busy, frame_err, parity_err, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_busy, frame_err, parity_err, overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_mv.sv
// uart_rx_mv: parametrised UART receiver with 3-sample majority voting,
// false-start rejection, framing/parity/overrun reporting and a valid/ready
// output register. Optional parity bit is compiled in with UART_RX_PARITY_EN.
module uart_rx_mv #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         uart_rxd,
    uart_rx_mv_if.master rx
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int MID          = BAUD_CNT_MAX / 2;
    localparam int CW           = $clog2(BAUD_CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID);
    localparam logic [CW-1:0] CNT_VOTE = CW'(MID + 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [1:0]           stop_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 samp0;
    logic                 samp1;
    logic                 stop_fail;
    logic                 done_ok;
    logic                 done_ferr;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
    logic                 done_perr;
`endif

    logic rxd_meta;
    logic rxd_sync;
    logic rxd_d1;
    logic settle;
    logic armed;

    logic start_edge;
    logic vote;
    logic at_s0;
    logic at_s1;
    logic at_vote;
    logic at_last;

    // Synchronise the line and arm edge detection only once it has been seen high after reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_d1   <= 1'b1;
            settle   <= 1'b0;
            armed    <= 1'b0;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_d1   <= rxd_sync;
            settle   <= 1'b1;
            if (settle && rxd_meta) begin
                armed <= 1'b1;
            end
        end
    end

    assign start_edge = armed & rxd_d1 & ~rxd_sync;
    assign at_s0      = (cnt == CNT_S0);
    assign at_s1      = (cnt == CNT_S1);
    assign at_vote    = (cnt == CNT_VOTE);
    assign at_last    = (cnt == CNT_LAST);
    assign vote       = (samp0 & samp1) | (samp0 & rxd_sync) | (samp1 & rxd_sync);

    // Frame FSM: baud timing, majority sampling, shifting and end-of-frame verdict
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= '0;
            shift_reg <= '0;
            samp0     <= 1'b1;
            samp1     <= 1'b1;
            stop_fail <= 1'b0;
            done_ok   <= 1'b0;
            done_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
            done_perr <= 1'b0;
`endif
        end else begin
            done_ok   <= 1'b0;
            done_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            done_perr <= 1'b0;
`endif
            if (state != IDLE && state != WAIT_IDLE) begin
                cnt <= at_last ? '0 : cnt + 1'b1;
                if (at_s0) samp0 <= rxd_sync;
                if (at_s1) samp1 <= rxd_sync;
            end
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    bit_idx   <= '0;
                    stop_idx  <= '0;
                    stop_fail <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_bad   <= 1'b0;
`endif
                    if (start_edge) state <= START;
                end
                START: begin
                    if (at_vote && vote) state <= IDLE;
                    else if (at_last)    state <= DATA;
                end
                DATA: begin
                    if (at_vote) shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                    if (at_last) begin
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (at_vote) par_bad <= vote ^ (^shift_reg) ^ PARITY_ODD;
                    if (at_last) state <= STOP;
                end
`endif
                STOP: begin
                    if (at_vote) begin
                        if (stop_idx == STOP_LAST) begin
                            if (!vote || stop_fail) begin
                                done_ferr <= 1'b1;
                                state     <= (shift_reg == '0) ? WAIT_IDLE : IDLE;
                            end
`ifdef UART_RX_PARITY_EN
                            else if (par_bad) begin
                                done_perr <= 1'b1;
                                state     <= IDLE;
                            end
`endif
                            else begin
                                done_ok <= 1'b1;
                                state   <= IDLE;
                            end
                        end else if (!vote) begin
                            stop_fail <= 1'b1;
                        end
                    end
                    if (at_last) stop_idx <= stop_idx + 1'b1;
                end
                WAIT_IDLE: begin
                    if (!rxd_sync)    cnt   <= '0;
                    else if (at_last) state <= IDLE;
                    else              cnt   <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: deliver the word, run the valid/ready handshake, pulse errors
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx.rx_data     <= '0;
            rx.rx_valid    <= 1'b0;
            rx.frame_err   <= 1'b0;
            rx.parity_err  <= 1'b0;
            rx.overrun_err <= 1'b0;
        end else begin
            rx.frame_err   <= done_ferr;
`ifdef UART_RX_PARITY_EN
            rx.parity_err  <= done_perr;
`else
            rx.parity_err  <= PARITY_ODD & 1'b0;
`endif
            rx.overrun_err <= 1'b0;
            if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;
            if (done_ok) begin
                if (!rx.rx_valid || rx.rx_ready) begin
                    rx.rx_data  <= shift_reg;
                    rx.rx_valid <= 1'b1;
                end else begin
                    rx.overrun_err <= 1'b1;
                end
            end
        end
    end

    assign rx.rx_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_mv.sv
// tb_uart_rx_mv: randomized frames against a queue-based reference model of
// the receiver; covers delivery, glitches, framing/break, overrun, spikes,
// optional parity and mid-frame reset.
module tb_uart_rx_mv;
    localparam int CLK_FREQ = 50_000_000;
    localparam int UART_BPS = 1_000_000;
    localparam int BIT      = CLK_FREQ / UART_BPS;
    localparam int MID      = BIT / 2;
    localparam int DBITS    = 8;
    localparam int SBITS    = 1;
    localparam bit PODD     = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DBITS + PBITS + SBITS;
    localparam int LATENCY    = FRAME_BITS * BIT - BIT / 2 + 5;

    logic clk = 1'b0;
    logic rst;
    logic uart_rxd;

    always #10 clk = ~clk;

    uart_rx_mv_if #(.DATA_BITS(DBITS)) rx_bus ();

    uart_rx_mv #(
        .CLK_FREQ  (CLK_FREQ),
        .UART_BPS  (UART_BPS),
        .DATA_BITS (DBITS),
        .STOP_BITS (SBITS),
        .PARITY_ODD(PODD)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .uart_rxd(uart_rxd),
        .rx      (rx_bus)
    );

    int checks   = 0;
    int failures = 0;

    // observed activity
    int cyc = 0;
    logic [DBITS-1:0] got[$];
    int ferr_cnt = 0, perr_cnt = 0, oerr_cnt = 0, rise_cnt = 0;
    int last_rise_cyc = 0, last_fall_cyc = 0;
    int busy_run = 0, last_busy_run = 0;
    bit busy_any = 1'b0;
    logic prev_valid = 1'b0;

    // reference model
    logic [DBITS-1:0] exp_got[$];
    int exp_ferr = 0, exp_perr = 0, exp_oerr = 0, exp_rise = 0;
    bit model_valid = 1'b0;
    logic [DBITS-1:0] model_word = '0;

    // Free-running cycle counter for latency measurement
    always @(posedge clk) cyc++;

    // Monitor: record accepted words, error pulses, valid rises and busy runs
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            busy_run   = 0;
        end else begin
            if (rx_bus.rx_valid && rx_bus.rx_ready) got.push_back(rx_bus.rx_data);
            if (rx_bus.rx_valid && !prev_valid) begin
                rise_cnt++;
                last_rise_cyc = cyc;
            end
            prev_valid = rx_bus.rx_valid;
            if (rx_bus.frame_err)   ferr_cnt++;
            if (rx_bus.parity_err)  perr_cnt++;
            if (rx_bus.overrun_err) oerr_cnt++;
            if (rx_bus.rx_busy) begin
                busy_run++;
                busy_any = 1'b1;
            end else if (busy_run != 0) begin
                last_busy_run = busy_run;
                busy_run = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic driveBit(input logic b, input bit spike, input int off);
        for (int c = 0; c < BIT; c++) begin
            uart_rxd = (spike && c == off) ? ~b : b;
            waitCycles(1);
        end
    endtask

    task automatic driveIdle(input int n);
        uart_rxd = 1'b1;
        waitCycles(n);
    endtask

    // Reference model: fate of one frame from its parameters
    task automatic modelFrame(input logic [DBITS-1:0] word, input bit stop_ok, input bit par_ok);
        if (!stop_ok) begin
            exp_ferr++;
        end else if (PBITS == 1 && !par_ok) begin
            exp_perr++;
        end else if (model_valid && !rx_bus.rx_ready) begin
            exp_oerr++;
        end else begin
            exp_rise++;
            if (rx_bus.rx_ready) exp_got.push_back(word);
            else begin
                model_valid = 1'b1;
                model_word  = word;
            end
        end
    endtask

    // Drive one serial frame (spike_bit = frame bit index to spike, 0 = none) and model it
    task automatic applyStimulus(input logic [DBITS-1:0] word, input bit stop_ok, input bit par_ok,
                                 input int spike_bit, input int spike_off);
        logic [15:0] fr;
        int n;
        fr = '1;
        n = 0;
        fr[n] = 1'b0; n++;
        for (int i = 0; i < DBITS; i++) begin
            fr[n] = word[i]; n++;
        end
        if (PBITS == 1) begin
            fr[n] = (^word) ^ PODD ^ !par_ok; n++;
        end
        for (int s = 0; s < SBITS; s++) begin
            fr[n] = (!stop_ok && s == SBITS - 1) ? 1'b0 : 1'b1; n++;
        end
        modelFrame(word, stop_ok, par_ok);
        last_fall_cyc = cyc;
        for (int k = 0; k < n; k++) driveBit(fr[k], (spike_bit != 0 && k == spike_bit), spike_off);
    endtask

    task automatic clearScore();
        got.delete();
        exp_got.delete();
        ferr_cnt = 0; perr_cnt = 0; oerr_cnt = 0; rise_cnt = 0;
        exp_ferr = 0; exp_perr = 0; exp_oerr = 0; exp_rise = 0;
    endtask

    task automatic compareScore(input string ph);
        checkOutput($sformatf("%s_count", ph), got.size(), exp_got.size());
        for (int i = 0; i < got.size() && i < exp_got.size(); i++)
            checkOutput($sformatf("%s_word%0d", ph, i), got[i], exp_got[i]);
        checkOutput($sformatf("%s_rises", ph), rise_cnt, exp_rise);
        checkOutput($sformatf("%s_frame_err", ph), ferr_cnt, exp_ferr);
        checkOutput($sformatf("%s_parity_err", ph), perr_cnt, exp_perr);
        checkOutput($sformatf("%s_overrun_err", ph), oerr_cnt, exp_oerr);
    endtask

    initial begin
        logic [DBITS-1:0] w;
        logic [DBITS-1:0] w2;
        int sb;
        bit sok;
        bit pok;

        rst = 1'b1;
        uart_rxd = 1'b1;
        rx_bus.rx_ready = 1'b1;
        waitCycles(5);
        @(negedge clk);
        checkOutput("reset_valid", rx_bus.rx_valid, 0);
        checkOutput("reset_data", rx_bus.rx_data, 0);
        checkOutput("reset_busy", rx_bus.rx_busy, 0);
        checkOutput("reset_errs", {rx_bus.frame_err, rx_bus.parity_err, rx_bus.overrun_err}, 0);
        waitCycles(1);
        rst = 1'b0;
        waitCycles(5);

        // Phase 1: fixed and random words back-to-back, random single-cycle spikes
        clearScore();
        applyStimulus(8'h55, 1, 1, 0, 0);
        checkOutput("p1_latency_ok", ((last_rise_cyc - last_fall_cyc) >= LATENCY - 2) &&
                                     ((last_rise_cyc - last_fall_cyc) <= LATENCY + 2), 1);
        applyStimulus(8'h01, 1, 1, 0, 0);
        applyStimulus(8'h02, 1, 1, 0, 0);
        w = '0;
        for (int f = 0; f < 10; f++) begin
            w  = DBITS'($urandom_range(0, 255));
            sb = ($urandom_range(0, 1) == 1) ? $urandom_range(1, DBITS) : 0;
            applyStimulus(w, 1, 1, sb, $urandom_range(MID - 3, MID + 6));
        end
        driveIdle(2 * BIT);
        compareScore("p1");
        checkOutput("p1_data_hold", rx_bus.rx_data, w);
        checkOutput("p1_valid_low", rx_bus.rx_valid, 0);

        // Phase 2: short low glitch is a false start
        clearScore();
        uart_rxd = 1'b0;
        waitCycles(12);
        driveIdle(2 * BIT);
        checkOutput("p2_busy_len_ok", (last_busy_run >= MID) && (last_busy_run <= MID + 4), 1);
        compareScore("p2");

        // Phase 3: framing errors followed by clean frames
        clearScore();
        applyStimulus(8'hA5, 0, 1, 0, 0);
        driveIdle(2 * BIT);
        applyStimulus(8'h3C, 1, 1, 0, 0);
        for (int f = 0; f < 5; f++) begin
            sok = ($urandom_range(0, 2) != 0);
            applyStimulus(DBITS'($urandom_range(1, 255)), sok, 1, 0, 0);
            if (!sok) driveIdle(2 * BIT);
        end
        driveIdle(2 * BIT);
        compareScore("p3");

        // Phase 3b: break (all-zero word, stop low) holds the receiver busy until line idles a full bit
        clearScore();
        applyStimulus('0, 0, 1, 0, 0);
        driveBit(1'b0, 0, 0);
        driveBit(1'b0, 0, 0);
        checkOutput("p3b_busy_in_break", rx_bus.rx_busy, 1);
        driveIdle(BIT / 2);
        checkOutput("p3b_busy_short_idle", rx_bus.rx_busy, 1);
        driveIdle(BIT + BIT / 2);
        checkOutput("p3b_busy_after_idle", rx_bus.rx_busy, 0);
        applyStimulus(DBITS'($urandom_range(0, 255)), 1, 1, 0, 0);
        driveIdle(BIT);
        compareScore("p3b");

        // Phase 4: overrun while the consumer stalls
        clearScore();
        rx_bus.rx_ready = 1'b0;
        w  = DBITS'($urandom_range(0, 255));
        w2 = ~w;
        applyStimulus(w, 1, 1, 0, 0);
        applyStimulus(w2, 1, 1, 0, 0);
        driveIdle(BIT);
        checkOutput("p4_valid_held", rx_bus.rx_valid, 1);
        checkOutput("p4_data_held", rx_bus.rx_data, w);
        rx_bus.rx_ready = 1'b1;
        exp_got.push_back(model_word);
        model_valid = 1'b0;
        waitCycles(3);
        checkOutput("p4_valid_drop", rx_bus.rx_valid, 0);
        compareScore("p4");

        // Phase 5: single-cycle spike around the centre of data bit 3 of 0xF0
        clearScore();
        for (int o = MID - 1; o <= MID + 5; o++) applyStimulus(8'hF0, 1, 1, 4, o);
        driveIdle(BIT);
        compareScore("p5");

`ifdef UART_RX_PARITY_EN
        // Phase 6: parity checking, including frame-error priority
        clearScore();
        applyStimulus(8'h07, 1, 1, 0, 0);
        applyStimulus(8'h07, 1, 0, 0, 0);
        for (int f = 0; f < 6; f++) begin
            sok = ($urandom_range(0, 3) != 0);
            pok = ($urandom_range(0, 1) == 1);
            applyStimulus(DBITS'($urandom_range(1, 255)), sok, pok, 0, 0);
            if (!sok) driveIdle(2 * BIT);
        end
        driveIdle(BIT);
        compareScore("p6");
`endif

        // Phase 7: reset mid-byte with the line low, then a clean frame
        clearScore();
        rx_bus.rx_ready = 1'b0;
        applyStimulus(DBITS'($urandom_range(1, 255)), 1, 1, 0, 0);
        driveIdle(BIT);
        driveBit(1'b0, 0, 0);
        driveBit(1'b0, 0, 0);
        driveBit(1'b0, 0, 0);
        rst = 1'b1;
        waitCycles(3);
        @(negedge clk);
        checkOutput("p7_rst_valid", rx_bus.rx_valid, 0);
        checkOutput("p7_rst_data", rx_bus.rx_data, 0);
        checkOutput("p7_rst_busy", rx_bus.rx_busy, 0);
        waitCycles(1);
        rst = 1'b0;
        model_valid = 1'b0;
        clearScore();
        busy_any = 1'b0;
        driveBit(1'b0, 0, 0);
        driveBit(1'b0, 0, 0);
        checkOutput("p7_no_false_start", busy_any, 0);
        driveIdle(2 * BIT);
        rx_bus.rx_ready = 1'b1;
        applyStimulus(DBITS'($urandom_range(0, 255)), 1, 1, 0, 0);
        driveIdle(BIT);
        compareScore("p7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
